// File: rtl/sdram_uart_defs.sv
// Shared constants and FSM encodings for the UART command path.
package sdram_uart_defs;

    localparam logic [7:0] HDR_WR_DEF = 8'h55;
    localparam logic [7:0] HDR_RD_DEF = 8'hAA;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_DATA = 3'b010,
        S_WAIT = 3'b100
    } cmd_state_t;

endpackage

// File: rtl/sync_fifo_8b.sv
// Byte FIFO with registered read data and a synchronous flush.
module sync_fifo_8b #(
    parameter int AW = 3
) (
    input  logic          sclk,
    input  logic          s_rst_n,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   cnt
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    // Flush dominates both ports in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge sclk) begin
        if (do_push) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            dout <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp   <= rp + 1'b1;
                dout <= mem[rp];
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_decode.sv
// Decodes UART bytes into write frames (buffered) and read commands.
module uart_cmd_decode
    import sdram_uart_defs::*;
#(
    parameter logic [7:0] HDR_WR      = HDR_WR_DEF,
    parameter logic [7:0] HDR_RD      = HDR_RD_DEF,
    parameter int         FRAME_LEN   = 4,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         FIFO_AW     = 3
) (
    input  logic               sclk,
    input  logic               s_rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               wr_trig,
    output logic               rd_trig,
    input  logic               wfifo_rd_en,
    output logic [7:0]         wfifo_rd_data,
    output logic               busy,
    output logic               frame_err,
    output logic [FIFO_AW:0]   fifo_cnt
);

    if (FRAME_LEN < 1 || FRAME_LEN > (1 << FIFO_AW)) begin : g_bad_len
        $error("FRAME_LEN must be in 1..2**FIFO_AW");
    end

    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BW-1:0] LAST    = BW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    cmd_state_t    state;
    logic [BW-1:0] byte_cnt;
    logic [TW-1:0] to_cnt;
    logic          push;
    logic          abort;
    logic          full;
    logic          empty;

    assign busy = (state != S_IDLE);
    assign push = (state == S_DATA) && rx_valid && !full;
    // Abort on an overflowing push or an inter-byte gap that ran out.
    assign abort = (state == S_DATA) &&
                   (rx_valid ? full : (to_cnt == TO_LAST));

    sync_fifo_8b #(
        .AW (FIFO_AW)
    ) u_fifo (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .push    (push),
        .din     (rx_data),
        .pop     (wfifo_rd_en),
        .flush   (abort),
        .dout    (wfifo_rd_data),
        .full    (full),
        .empty   (empty),
        .cnt     (fifo_cnt)
    );

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state     <= S_IDLE;
            byte_cnt  <= '0;
            to_cnt    <= '0;
            wr_trig   <= 1'b0;
            rd_trig   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_trig   <= 1'b0;
            rd_trig   <= 1'b0;
            frame_err <= 1'b0;
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (rx_valid && rx_data == HDR_WR) begin
                        state    <= S_DATA;
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                    end else if (rx_valid && rx_data == HDR_RD) begin
                        rd_trig <= 1'b1;
                    end
                end
                (state == S_DATA): begin
                    if (abort) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b1;
                        byte_cnt  <= '0;
                        to_cnt    <= '0;
                    end else if (rx_valid) begin
                        to_cnt <= '0;
                        if (byte_cnt == LAST) begin
                            wr_trig  <= 1'b1;
                            state    <= S_WAIT;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                (state == S_WAIT): begin
                    if (empty && !wfifo_rd_en) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
